// File: rtl/button_conditioner_pkg.sv
// Shared definitions for push-button input stages: FSM state encoding and
// default timing constants.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK_HIGH = 2'd1,
    PRESSED    = 2'd2,
    CHECK_LOW  = 2'd3
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_LONG_CYCLES     = 16;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Single-bit two-flop synchroniser for an input asynchronous to clk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button; emits the clean level plus
// registered press, release and long-press strobes.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYCLES - 1);

  logic button_s;

  btn_state_e    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          button_q, button_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (button_s)
  );

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    button_d   = button_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Hold time accumulates across low glitches; saturation makes long_d one-shot.
    if (state_q == PRESSED || state_q == CHECK_LOW) begin
      if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
      long_d = (hold_cnt_q == HOLD_LONG);
    end

    case (state_q)
      IDLE: begin
        if (button_s) begin
          state_d   = CHECK_HIGH;
          deb_cnt_d = '0;
        end
      end
      CHECK_HIGH: begin
        if (!button_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          button_d   = 1'b1;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!button_s) begin
          state_d   = CHECK_LOW;
          deb_cnt_d = '0;
        end
      end
      CHECK_LOW: begin
        if (button_s) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          // Release wins over a coincident long-press so strobes stay exclusive.
          state_d   = IDLE;
          button_d  = 1'b0;
          release_d = 1'b1;
          long_d    = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      button_q   <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      button_q   <= button_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign button        = button_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Upstream input stage for the dice/traffic-light multiplexer. It takes the raw, asynchronous, bouncy push-button and synchronises and debounces it. It then drives the clean `button` level that the dice roller consumes. It also emits one-cycle press, release and long-press strobes for future control logic, e.g. a long press forcing `sel` toggle.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (>=1; 4 for sim, ~1_000_000 on board)
LONG_CYCLES, 16, cycles `button` must stay high before long_press fires (>=2)

Ports:
clk            input   1  system clock, all logic on rising edge
rst            input   1  asynchronous, active-high reset
button_raw     input   1  raw push-button, asynchronous to clk, may bounce
button         output  1  debounced level, feeds muxtd.button
press_pulse    output  1  one-cycle strobe on accepted 0->1
release_pulse  output  1  one-cycle strobe on accepted 1->0
long_press     output  1  one-cycle strobe, at most once per press

Behaviour:
- Reset (async assert, sync release): sync flops=0, state=IDLE, counters=0.
- Reset values of all outputs: button=0, press_pulse=0, release_pulse=0, long_press=0.
- Synchroniser: 2 flops. button_s = second flop. No logic reads button_raw directly.
- FSM states: IDLE (button=0), CHECK_HIGH, PRESSED (button=1), CHECK_LOW.
- IDLE: button_s=1 -> CHECK_HIGH, deb_cnt<=0.
- CHECK_HIGH, button_s=0 -> IDLE. Bounce rejected; no strobe.
- CHECK_HIGH, button_s=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Registered button<=1; press_pulse=1 for exactly that cycle; hold_cnt<=0.
- CHECK_HIGH, otherwise: deb_cnt++.
- PRESSED: hold_cnt++ each cycle, saturating at LONG_CYCLES. long_press=1 only in the cycle hold_cnt reaches LONG_CYCLES-1.
- PRESSED, button_s=0 -> CHECK_LOW, deb_cnt<=0.
- CHECK_LOW: button stays 1; hold_cnt keeps counting/saturating.
- CHECK_LOW, button_s=1 -> PRESSED. No strobes; hold_cnt not cleared.
- CHECK_LOW, button_s=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE. button<=0; release_pulse=1 for that cycle.
- CHECK_LOW, otherwise: deb_cnt++.
- Latency: a clean edge on button_raw first sampled at edge k gives button/strobe changes visible after edge k+2+DEBOUNCE_CYCLES. With the default, that is 6 edges.
- long_press fires LONG_CYCLES edges after press_pulse, if not released. It never fires twice in one press. A press released early produces no long_press.
- Strobes are registered and mutually exclusive in any cycle.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(LONG_CYCLES+1) bits. No wrap: hold_cnt saturates, deb_cnt is cleared on every state entry.
- Reset mid-press: button drops to 0 immediately with no release_pulse. After release, the block re-debounces from IDLE even if button_raw is still high.
- Glitch shorter than DEBOUNCE_CYCLES samples in either stable state: no change on any output.

Decomposition:
- Shared header/package: state encodings (IDLE=2'd0, CHECK_HIGH=2'd1, PRESSED=2'd2, CHECK_LOW=2'd3) and default parameter constants, reused by future input stages.
- One sub-module, sync_2ff (1-bit two-flop synchroniser with async reset), instantiated once.
- FSM and counters stay in button_conditioner.

Test Plan:
1. rst=1 for 3 cycles with button_raw=1, then release -> all outputs 0 during reset. button rises 6 edges after first post-reset sample, press_pulse high exactly 1 cycle.
2. Clean press, held 30 cycles (defaults) -> press_pulse once. long_press once, 16 edges after press_pulse. No further long_press while held.
3. Bounce: raw 1 for 2 cycles, 0 for 1, 1 for 2, 0 -> button stays 0, no strobes.
4. Held press with a 2-cycle low glitch -> button stays 1, no release_pulse, no second press_pulse. Final clean release -> release_pulse once, button=0 6 edges later.
5. Short press of 8 stable cycles -> press_pulse and release_pulse each once, no long_press.
6. Assert rst while button=1, hold_cnt=10 -> button=0 asynchronously, no release_pulse. After reset, raw still high -> new press_pulse after 6 edges.
